pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-side controller for the 5-stage RISC-V pipeline: sole driver of next_pc/pc_en into programcounter.
//  Arbitrates sequential fetch, ID-stage jumps, EX-stage branch redirects, load-use stalls and halt/resume.
//  Produces IF/ID and ID/EX flush strobes; sequences boot and a drain-then-halt debug stop.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address loaded in BOOT
//  DRAIN_CYCLES  4              cycles held in DRAIN before HALTED (pipeline depth past IF)
//  TRAP_VECTOR   32'h0000_0100  trap handler address (PCSEQ_TRAP_EN only)
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high
//  pc             in   32  current PC from programcounter
//  stall          in   1   load-use hazard: hold IF and ID
//  jump_valid     in   1   JAL/JALR resolved in ID
//  jump_target    in   32  jump destination
//  branch_taken   in   1   taken branch resolved in EX
//  branch_target  in   32  branch destination
//  halt_req       in   1   level; request stop of fetch
//  resume         in   1   pulse; leave HALTED
//  next_pc        out  32  PC value loaded when pc_en=1
//  pc_en          out  1   PC write enable
//  if_id_flush    out  1   squash IF/ID register this cycle
//  id_ex_flush    out  1   squash ID/EX register this cycle
//  halted         out  1   registered; 1 in HALTED state
// BEHAVIOUR
//  FSM: BOOT -> RUN -> DRAIN -> HALTED -> RUN. reset: state=BOOT, drain_cnt=0, resume_pc=RESET_VECTOR, halted=0.
//  BOOT (1 cycle): next_pc=RESET_VECTOR, pc_en=1, both flushes=1; -> RUN.
//  RUN priority (highest first), all outputs combinational from inputs+state:
//   1 branch_taken: next_pc=branch_target, pc_en=1, if_id_flush=1, id_ex_flush=1 (overrides stall and jump).
//   2 jump_valid & !stall: next_pc=jump_target, pc_en=1, if_id_flush=1, id_ex_flush=0.
//   3 stall: pc_en=0, flushes=0 (jump_valid ignored; ID re-presents it after stall).
//   4 else: next_pc=pc+32'd4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), pc_en=1.
//  halt_req in RUN: the redirect/sequential target of that cycle is stored in resume_pc with pc_en=0 and
//   if_id_flush=1; -> DRAIN, drain_cnt=0.
//  DRAIN: pc_en=0, if_id_flush=1; branch_taken still overwrites resume_pc and pulses id_ex_flush;
//   jump_valid ignored (jump already squashed). drain_cnt++; at DRAIN_CYCLES-1 -> HALTED.
//  HALTED: pc_en=0, halted=1. resume: next_pc=resume_pc, pc_en=1; -> RUN. halt_req still high -> stay HALTED.
//  resume outside HALTED: ignored. Reset in any state overrides all: outputs follow BOOT next cycle.
//  Targets used unmodified; misalignment is the producer's concern (trap path below when enabled).
// CONFIGURATION
//  PCSEQ_TRAP_EN defined: ports trap_req(in,1), trap_pc(in,32), mret(in,1), mepc(out,32) added.
//   trap_req has priority above branch_taken in RUN/DRAIN: mepc<=trap_pc, next_pc=TRAP_VECTOR, pc_en=1,
//   both flushes=1. mret (priority below trap, above branch): next_pc=mepc, both flushes=1. mepc reset 0.
//   Also raises trap when a redirect target has bits[1:0]!=0 (mepc<=redirecting pc).
//  Undefined: ports absent, no mepc register, TRAP_VECTOR unused; behaviour exactly as above.
// STRUCTURE
//  Shared pipeline package: pcseq_state_t enum (BOOT,RUN,DRAIN,HALTED), PC_INC=32'd4, XLEN=32.
//  Single module; no sub-module (next-pc mux and FSM are one unit). programcounter stays external.
// TESTING
//  1 reset 2 cycles, release -> BOOT cycle next_pc=RESET_VECTOR pc_en=1; then pc 0,4,8,C each cycle.
//  2 pc=8, stall=1 two cycles -> pc_en=0, pc holds 8; stall=0 -> next_pc=C.
//  3 pc=10, stall=1 & branch_taken=1 target 40 -> pc_en=1, next_pc=40, both flushes=1.
//  4 jump_valid target 80 with branch_taken target 20 same cycle -> next_pc=20; jump alone -> 80, only if_id_flush.
//  5 halt_req at pc=24, branch_taken to 60 during DRAIN -> halted=1 after DRAIN_CYCLES; resume -> next_pc=60.
//  6 pc=FFFF_FFFC sequential -> next_pc=0; reset mid-DRAIN -> halted=0, BOOT next cycle.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-pipeline types and constants for the PC sequencer.
package pc_sequencer_pkg;

   localparam int          XLEN   = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } pcseq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: next-pc mux, flush strobes, boot and drain-then-halt sequencing.
// Optional trap/mret path enabled by defining PCSEQ_TRAP_EN.
//
// state  | meaning
// BOOT   | one cycle after reset, load RESET_VECTOR, flush IF/ID and ID/EX
// RUN    | normal fetch: branch > jump > stall > sequential
// DRAIN  | fetch stopped, let in-flight instructions retire for DRAIN_CYCLES
// HALTED | fetch stopped until resume with halt_req low
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              DRAIN_CYCLES = 4
`ifdef PCSEQ_TRAP_EN
   ,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   input  logic            stall,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_target,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            halt_req,
   input  logic            resume,
`ifdef PCSEQ_TRAP_EN
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   output logic [XLEN-1:0] mepc,
`endif
   output logic [XLEN-1:0] next_pc,
   output logic            pc_en,
   output logic            if_id_flush,
   output logic            id_ex_flush,
   output logic            halted
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   pcseq_state_t    state, state_nxt;
   logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
   logic [XLEN-1:0] resume_pc, resume_pc_nxt;
`ifdef PCSEQ_TRAP_EN
   logic [XLEN-1:0] mepc_nxt;
   logic            misaligned;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= BOOT;
         drain_cnt <= '0;
         resume_pc <= RESET_VECTOR;
         halted    <= 1'b0;
`ifdef PCSEQ_TRAP_EN
         mepc      <= '0;
`endif
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         resume_pc <= resume_pc_nxt;
         halted    <= (state_nxt == HALTED);
`ifdef PCSEQ_TRAP_EN
         mepc      <= mepc_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      resume_pc_nxt = resume_pc;
      next_pc       = pc;
      pc_en         = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
`ifdef PCSEQ_TRAP_EN
      mepc_nxt      = mepc;
      misaligned    = 1'b0;
`endif
      case (state)
         BOOT: begin
            next_pc     = RESET_VECTOR;
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
         end
         RUN: begin
            if (branch_taken) begin
               next_pc     = branch_target;
               pc_en       = 1'b1;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (jump_valid && !stall) begin
               next_pc     = jump_target;
               pc_en       = 1'b1;
               if_id_flush = 1'b1;
            end else if (stall) begin
               next_pc = pc;
            end else begin
               next_pc = pc + PC_INC;
               pc_en   = 1'b1;
            end
            // Halting captures this cycle's target instead of fetching it.
            if (halt_req) begin
               resume_pc_nxt = next_pc;
               pc_en         = 1'b0;
               if_id_flush   = 1'b1;
               drain_cnt_nxt = '0;
               state_nxt     = DRAIN;
            end
         end
         DRAIN: begin
            if_id_flush = 1'b1;
            if (branch_taken) begin
               resume_pc_nxt = branch_target;
               id_ex_flush   = 1'b1;
            end
            if (drain_cnt == CNT_LAST) begin
               state_nxt = HALTED;
            end else begin
               drain_cnt_nxt = drain_cnt + 1'b1;
            end
         end
         HALTED: begin
            if (resume && !halt_req) begin
               next_pc   = resume_pc;
               pc_en     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = BOOT;
      endcase
`ifdef PCSEQ_TRAP_EN
      if (state == RUN || state == DRAIN) begin
         misaligned = (branch_taken && (branch_target[1:0] != 2'b00)) ||
                      ((state == RUN) && !branch_taken && jump_valid && !stall &&
                       (jump_target[1:0] != 2'b00));
         if (trap_req || misaligned) begin
            mepc_nxt      = trap_req ? trap_pc : pc;
            next_pc       = TRAP_VECTOR;
            pc_en         = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            resume_pc_nxt = resume_pc;
            drain_cnt_nxt = '0;
            state_nxt     = RUN;
         end else if (mret) begin
            next_pc       = mepc;
            pc_en         = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            resume_pc_nxt = resume_pc;
            drain_cnt_nxt = '0;
            state_nxt     = RUN;
         end
      end
`endif
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default build): expected outputs queued per driven cycle.
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        stall, jump_valid, branch_taken, halt_req, resume;
   logic [31:0] jump_target, branch_target;
   logic [31:0] next_pc;
   logic        pc_en, if_id_flush, id_ex_flush, halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic        chk_npc;
      logic [31:0] npc;
      logic        en;
      logic        fi;
      logic        fe;
      logic        h;
   } exp_t;

   exp_t exp_q[$];

   pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .DRAIN_CYCLES(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .pc           (pc),
      .stall        (stall),
      .jump_valid   (jump_valid),
      .jump_target  (jump_target),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .halt_req     (halt_req),
      .resume       (resume),
      .next_pc      (next_pc),
      .pc_en        (pc_en),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .halted       (halted)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 0; jump_valid = 0; branch_taken = 0; halt_req = 0; resume = 0;
      jump_target = '0; branch_target = '0;
   endtask

   // Queue expectation for the cycle just driven, compare at negedge, then act as the PC register.
   task automatic step(input string tag, input logic chk_npc, input logic [31:0] npc,
                       input logic en, input logic fi, input logic fe, input logic h);
      exp_t e, got;
      logic        s_en;
      logic [31:0] s_npc;
      e.tag = tag; e.chk_npc = chk_npc; e.npc = npc; e.en = en; e.fi = fi; e.fe = fe; e.h = h;
      exp_q.push_back(e);
      @(negedge clock);
      got = exp_q.pop_front();
      if (got.chk_npc) check({got.tag, ".next_pc"}, next_pc, got.npc);
      check({got.tag, ".pc_en"},  {31'd0, pc_en},       {31'd0, got.en});
      check({got.tag, ".if_id"},  {31'd0, if_id_flush}, {31'd0, got.fi});
      check({got.tag, ".id_ex"},  {31'd0, id_ex_flush}, {31'd0, got.fe});
      check({got.tag, ".halted"}, {31'd0, halted},      {31'd0, got.h});
      s_en = pc_en; s_npc = next_pc;
      @(posedge clock);
      #1;
      if (s_en) pc = s_npc;
   endtask

   initial begin
      idle_inputs();
      pc = 32'h0;
      reset = 1;
      @(posedge clock); @(posedge clock); #1;
      reset = 0;

      // Boot and sequential fetch
      step("boot", 1, 32'h0, 1, 1, 1, 0);
      check("boot_pc", pc, 32'h0);
      step("seq0", 1, 32'h4, 1, 0, 0, 0);
      step("seq4", 1, 32'h8, 1, 0, 0, 0);
      step("seq8", 1, 32'hC, 1, 0, 0, 0);
      check("seq_pc", pc, 32'hC);

      // Load-use stall holds PC
      pc = 32'h8; stall = 1;
      step("stall1", 0, 32'h0, 0, 0, 0, 0);
      step("stall2", 0, 32'h0, 0, 0, 0, 0);
      check("stall_pc_hold", pc, 32'h8);
      stall = 0;
      step("unstall", 1, 32'hC, 1, 0, 0, 0);

      // Branch overrides stall
      pc = 32'h10; stall = 1; branch_taken = 1; branch_target = 32'h40;
      step("br_stall", 1, 32'h40, 1, 1, 1, 0);
      idle_inputs();

      // Branch beats jump; jump alone; jump during stall ignored
      jump_valid = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h20;
      step("br_jmp", 1, 32'h20, 1, 1, 1, 0);
      branch_taken = 0;
      step("jmp", 1, 32'h80, 1, 1, 0, 0);
      stall = 1;
      step("jmp_stall", 0, 32'h0, 0, 0, 0, 0);
      idle_inputs();

      // Resume outside HALTED is ignored
      pc = 32'h200; resume = 1;
      step("resume_run", 1, 32'h204, 1, 0, 0, 0);
      resume = 0;

      // Sequential wrap
      pc = 32'hFFFF_FFFC;
      step("wrap", 1, 32'h0, 1, 0, 0, 0);

      // Halt, branch during drain, resume to branch target
      pc = 32'h24; halt_req = 1;
      step("halt", 0, 32'h0, 0, 1, 0, 0);
      branch_taken = 1; branch_target = 32'h60;
      step("drain0_br", 0, 32'h0, 0, 1, 1, 0);
      branch_taken = 0; jump_valid = 1; jump_target = 32'h80;
      step("drain1_jmp", 0, 32'h0, 0, 1, 0, 0);
      jump_valid = 0;
      step("drain2", 0, 32'h0, 0, 1, 0, 0);
      step("drain3", 0, 32'h0, 0, 1, 0, 0);
      step("halted", 0, 32'h0, 0, 0, 0, 1);
      resume = 1;
      step("resume_held", 0, 32'h0, 0, 0, 0, 1);
      halt_req = 0;
      step("resume", 1, 32'h60, 1, 0, 0, 1);
      resume = 0;
      check("resume_pc", pc, 32'h60);
      step("after_resume", 1, 32'h64, 1, 0, 0, 0);

      // Reset mid-drain
      pc = 32'h100; halt_req = 1;
      step("halt2", 0, 32'h0, 0, 1, 0, 0);
      step("drain2_0", 0, 32'h0, 0, 1, 0, 0);
      idle_inputs();
      reset = 1;
      @(posedge clock); #1;
      reset = 0;
      step("reboot", 1, 32'h0, 1, 1, 1, 0);
      step("reboot_seq", 1, 32'h4, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
